// File: rtl/sine_pkg.sv
// Shared definitions for the quarter-sine oscillator blocks: default widths,
// the scheduler state encoding and the phase-to-table helper functions.
package sine_pkg;

   localparam int SINE_BITSIZE   = 24;
   localparam int SINE_PHASESIZE = 16;
   localparam int SINE_TABLESIZE = 9;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      ACC,
      DONE
   } state_t;

   // Fold a full-cycle phase into a quarter-table address: odd quadrants read
   // the table backwards so only 0..90 degrees needs to be stored.
   function automatic logic [SINE_TABLESIZE-1:0] fold_addr(
      input logic [SINE_PHASESIZE-1:0] p
   );
      logic [SINE_TABLESIZE-1:0] idx;
      idx = p[SINE_PHASESIZE-3 -: SINE_TABLESIZE];
      return p[SINE_PHASESIZE-2] ? ~idx : idx;
   endfunction

   // The second half of the cycle is the negated first half.
   function automatic logic neg_bit(input logic [SINE_PHASESIZE-1:0] p);
      return p[SINE_PHASESIZE-1];
   endfunction

endpackage

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one quarter-sine table across VOICES phase accumulators.
// One frame per lrclk rising edge: each voice is fetched, looked up,
// sign-corrected and summed, then the averaged mix is published on out.
module sine_voice_scheduler
   import sine_pkg::*;
#(
   parameter int BITSIZE   = SINE_BITSIZE,
   parameter int PHASESIZE = SINE_PHASESIZE,
   parameter int TABLESIZE = SINE_TABLESIZE,
   parameter int VOICES    = 4,
   parameter int VOICEBITS = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 lrclk,
   input  logic                 cfg_we,
   input  logic [VOICEBITS-1:0] cfg_addr,
   input  logic [PHASESIZE-1:0] cfg_freq,
   input  logic                 cfg_enable,
   output logic                 rom_en,
   output logic [TABLESIZE-1:0] rom_addr,
   input  logic [BITSIZE-1:0]   rom_data,
   output logic [BITSIZE-1:0]   out,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 overrun
);

   localparam int ACCW = BITSIZE + VOICEBITS;

   logic [PHASESIZE-1:0]   phase [VOICES];
   logic [PHASESIZE-1:0]   freq  [VOICES];
   logic [VOICES-1:0]      enable;
   logic [VOICES-1:0]      muted;

   state_t                 state;
   logic [VOICEBITS-1:0]   voice;
   logic [VOICEBITS-1:0]   next_voice;
   logic [PHASESIZE-1:0]   cur_phase;
   logic [PHASESIZE-1:0]   next_phase;
   logic                   neg;
   logic                   cur_en;
   logic [BITSIZE-1:0]     data_q;
   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] data_ext;
   logic signed [ACCW-1:0] term;
   logic                   wrap;

   logic                   lr_meta;
   logic                   lr_sync;
   logic                   lr_prev;
   logic                   lr_rise;

   // Bring lrclk into the clk domain and keep one extra stage for edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lr_meta <= 1'b0;
         lr_sync <= 1'b0;
         lr_prev <= 1'b0;
      end else begin
         lr_meta <= lrclk;
         lr_sync <= lr_meta;
         lr_prev <= lr_sync;
      end
   end

   assign lr_rise    = lr_sync & ~lr_prev;
   assign next_voice = voice + 1'b1;
   assign wrap       = next_phase < cur_phase;

   // Signed contribution of the current voice; muted voices contribute nothing.
   always_comb begin
      data_ext = {{VOICEBITS{data_q[BITSIZE-1]}}, data_q};
      term     = '0;
      if (!muted[voice]) begin
         term = neg ? -data_ext : data_ext;
      end
   end

   // Per-voice configuration; picked up when the voice is next fetched.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < VOICES; i++) begin
            freq[i] <= '0;
         end
         enable <= '0;
      end else if (cfg_we) begin
         freq[cfg_addr]   <= cfg_freq;
         enable[cfg_addr] <= cfg_enable;
      end
   end

   // Frame sequencer: FETCH/WAIT/ACC per voice, then DONE publishes the mix.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         voice      <= '0;
         rom_en     <= 1'b0;
         rom_addr   <= '0;
         busy       <= 1'b0;
         out        <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         acc        <= '0;
         cur_phase  <= '0;
         next_phase <= '0;
         neg        <= 1'b0;
         cur_en     <= 1'b0;
         data_q     <= '0;
         muted      <= '0;
         for (int i = 0; i < VOICES; i++) begin
            phase[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         rom_en    <= 1'b0;
         if (lr_rise && state != IDLE) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (lr_rise) begin
                  state    <= FETCH;
                  voice    <= '0;
                  busy     <= 1'b1;
                  rom_en   <= 1'b1;
                  rom_addr <= fold_addr(phase[0]);
               end
            end
            FETCH: begin
               cur_phase  <= phase[voice];
               next_phase <= phase[voice] + freq[voice];
               neg        <= neg_bit(phase[voice]);
               cur_en     <= enable[voice];
               state      <= WAIT;
            end
            WAIT: begin
               data_q <= rom_data;
               state  <= ACC;
            end
            ACC: begin
               acc <= acc + term;
               if (cur_en) begin
                  phase[voice] <= next_phase;
                  muted[voice] <= 1'b0;
               end else if (!muted[voice]) begin
                  if (wrap) begin
                     phase[voice] <= '0;
                     muted[voice] <= 1'b1;
                  end else begin
                     phase[voice] <= next_phase;
                  end
               end else begin
                  phase[voice] <= '0;
               end
               if (voice == VOICEBITS'(VOICES - 1)) begin
                  state <= DONE;
               end else begin
                  voice    <= next_voice;
                  rom_en   <= 1'b1;
                  rom_addr <= fold_addr(phase[next_voice]);
                  state    <= FETCH;
               end
            end
            DONE: begin
               out       <= BITSIZE'(acc >>> VOICEBITS);
               out_valid <= 1'b1;
               acc       <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Self-checking bench for sine_voice_scheduler: a registered ROM model holding
// index*1000 and a per-voice behavioural oscillator model built from the
// phase/quadrant rules.
module tb_sine_voice_scheduler;

   logic        clk = 1'b0;
   logic        resetn;
   logic        lrclk;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_freq;
   logic        cfg_enable;
   logic        rom_en;
   logic [8:0]  rom_addr;
   logic [23:0] rom_data;
   logic [23:0] out;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   int m_phase [4];
   int m_freq  [4];
   bit m_en    [4];
   bit m_muted [4];

   sine_voice_scheduler dut (
      .clk        (clk),
      .resetn     (resetn),
      .lrclk      (lrclk),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_freq   (cfg_freq),
      .cfg_enable (cfg_enable),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Table model with one clock of read latency.
   always @(posedge clk) begin
      if (rom_en) rom_data <= 24'(int'(rom_addr) * 1000);
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   function automatic void modelReset();
      for (int v = 0; v < 4; v++) begin
         m_phase[v] = 0;
         m_freq[v]  = 0;
         m_en[v]    = 0;
         m_muted[v] = 0;
      end
   endfunction

   // Sine sample for a 16-bit phase from a 512-entry quarter table of i*1000.
   function automatic int sineVal(input int p);
      int quad;
      int idx;
      int v;
      quad = p / 16384;
      idx  = (p / 32) % 512;
      if (quad == 1 || quad == 3) idx = 511 - idx;
      v = idx * 1000;
      if (p >= 32768) v = -v;
      return v;
   endfunction

   // One frame of the reference: sum all voices, advance phases, average.
   function automatic int modelFrame();
      int sum;
      int np;
      sum = 0;
      for (int v = 0; v < 4; v++) begin
         if (!m_muted[v]) sum += sineVal(m_phase[v]);
         np = m_phase[v] + m_freq[v];
         if (m_en[v]) begin
            m_phase[v] = np % 65536;
            m_muted[v] = 0;
         end else if (!m_muted[v]) begin
            if (np >= 65536) begin
               m_phase[v] = 0;
               m_muted[v] = 1;
            end else begin
               m_phase[v] = np;
            end
         end else begin
            m_phase[v] = 0;
         end
      end
      return sum >>> 2;
   endfunction

   // Single config write between frames; the model sees it immediately.
   task automatic applyStimulus(input int a, input int f, input bit e);
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_addr   = 2'(a);
      cfg_freq   = 16'(f);
      cfg_enable = e;
      @(negedge clk);
      cfg_we = 1'b0;
      m_freq[a] = f;
      m_en[a]   = e;
   endtask

   task automatic resetDut();
      resetn     = 1'b0;
      lrclk      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_freq   = '0;
      cfg_enable = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      modelReset();
      repeat (2) @(negedge clk);
   endtask

   // Run one frame, optionally writing config during the WAIT of voice 1.
   task automatic runFrame(input bit inject, input int ia, input int ifq, input bit ien,
                           output int got);
      int busy_cnt;
      int fetch_cnt;
      bit seen;
      bit injected;
      int expv;
      busy_cnt  = 0;
      fetch_cnt = 0;
      seen      = 0;
      injected  = 0;
      got       = 0;
      @(negedge clk);
      lrclk = 1'b1;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (cfg_we) cfg_we = 1'b0;
         if (out_valid) begin
            seen = 1;
            got  = int'($signed(out));
         end else begin
            if (busy) busy_cnt++;
            if (rom_en) begin
               fetch_cnt++;
            end else if (inject && !injected && fetch_cnt == 2) begin
               cfg_we     = 1'b1;
               cfg_addr   = 2'(ia);
               cfg_freq   = 16'(ifq);
               cfg_enable = ien;
               injected   = 1;
            end
         end
      end
      cfg_we = 1'b0;
      lrclk  = 1'b0;
      if (!seen) checkOutput("frame_timeout", 0, 1);
      expv = modelFrame();
      checkOutput("frame_out", got, expv);
      checkOutput("frame_len", busy_cnt, 13);
      checkOutput("busy_at_valid", int'(busy), 0);
      @(negedge clk);
      checkOutput("valid_pulse", int'(out_valid), 0);
      repeat (2) @(negedge clk);
      if (inject) begin
         m_freq[ia] = ifq;
         m_en[ia]   = ien;
      end
   endtask

   initial begin
      int got;
      int nvalid;
      int fetch_cnt;
      bit hit;
      int exp_v0 [4];
      exp_v0 = '{0, 127750, 0, -127750};
      rom_data = '0;

      // Reset state
      resetn     = 1'b0;
      lrclk      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_freq   = '0;
      cfg_enable = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out", int'(out), 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      checkOutput("rst_rom_en", int'(rom_en), 0);
      checkOutput("rst_rom_addr", int'(rom_addr), 0);
      resetDut();

      // Single voice at a quarter cycle per frame
      applyStimulus(0, 16'h4000, 1);
      for (int i = 0; i < 4; i++) begin
         runFrame(0, 0, 0, 0, got);
         checkOutput("v0_quarter", got, exp_v0[i]);
      end

      // All voices in phase
      resetDut();
      for (int v = 0; v < 4; v++) applyStimulus(v, 16'h4000, 1);
      runFrame(0, 0, 0, 0, got);
      checkOutput("all4_f1", got, 0);
      runFrame(0, 0, 0, 0, got);
      checkOutput("all4_f2", got, 511000);

      // Randomised configurations and mid-run rewrites
      resetDut();
      for (int v = 0; v < 4; v++) applyStimulus(v, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      for (int f = 0; f < 12; f++) begin
         runFrame(0, 0, 0, 0, got);
         if ($urandom_range(0, 1) == 1)
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      end

      // Disabled voice finishes its cycle, then stays muted at zero
      resetDut();
      applyStimulus(0, 16'h2000, 1);
      for (int i = 0; i < 5; i++) runFrame(0, 0, 0, 0, got);
      applyStimulus(0, 16'h2000, 0);
      for (int i = 0; i < 3; i++) runFrame(0, 0, 0, 0, got);
      for (int i = 0; i < 3; i++) begin
         runFrame(0, 0, 0, 0, got);
         checkOutput("muted_zero", got, 0);
      end

      // Frequency write during WAIT of voice 1 only affects the next frame
      resetDut();
      applyStimulus(1, 16'h1000, 1);
      runFrame(1, 1, 16'h3000, 1, got);
      runFrame(0, 0, 0, 0, got);
      runFrame(0, 0, 0, 0, got);
      checkOutput("late_write_f3", got, 127750);

      // lrclk edges every 8 clk: overrun sticks, only whole frames publish
      resetDut();
      checkOutput("ovr_clear", int'(overrun), 0);
      applyStimulus(0, 16'h4000, 1);
      nvalid = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            nvalid++;
            checkOutput("ovr_frame_out", int'($signed(out)), modelFrame());
         end
         lrclk = (cyc < 64) ? (((cyc / 4) % 2) == 0) : 1'b0;
      end
      checkOutput("ovr_frames", nvalid, 4);
      checkOutput("ovr_set", int'(overrun), 1);
      repeat (20) @(negedge clk);
      checkOutput("ovr_sticky", int'(overrun), 1);

      // Reset asserted during ACC of voice 2 aborts the frame
      @(negedge clk);
      lrclk = 1'b1;
      fetch_cnt = 0;
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (rom_en) fetch_cnt++;
         if (fetch_cnt == 3 && !rom_en) begin
            @(negedge clk);
            resetn = 1'b0;
            hit = 1;
         end
      end
      if (!hit) checkOutput("abort_timeout", 0, 1);
      #1;
      checkOutput("abort_out", int'(out), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_overrun", int'(overrun), 0);
      lrclk = 1'b0;
      nvalid = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      resetn = 1'b1;
      modelReset();
      repeat (6) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      checkOutput("abort_no_valid", nvalid, 0);
      for (int v = 0; v < 4; v++) applyStimulus(v, 16'h4000 + v * 16'h0800, 1);
      runFrame(0, 0, 0, 0, got);
      checkOutput("after_abort_f1", got, 0);
      runFrame(0, 0, 0, 0, got);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sine_voice_scheduler.md
Name: sine_voice_scheduler

Overview:
Time-multiplexes one shared quarter-sine lookup table across VOICES independent phase-accumulator oscillators. Runs on the fast system clock and processes one frame per rising edge of the audio lrclk. Each voice's phase is advanced, folded into a table address, looked up, sign-corrected and summed. The averaged mix is presented as one sample per frame to the codec output path, replacing per-voice sine generator instances and their private tables.

Parameters:
BITSIZE, 24, sample width of table entries and output
PHASESIZE, 16, phase accumulator and frequency word width
TABLESIZE, 9, log2 of quarter-table depth
VOICES, 4, number of oscillators, power of two
VOICEBITS, 2, log2(VOICES)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
lrclk  in  1  sample-rate clock, asynchronous to clk
cfg_we  in  1  config write strobe, one clk cycle
cfg_addr  in  VOICEBITS  voice index for write
cfg_freq  in  PHASESIZE  frequency word for addressed voice
cfg_enable  in  1  enable bit for addressed voice
rom_en  out  1  table read strobe
rom_addr  out  TABLESIZE  table read address
rom_data  in  BITSIZE  table data, valid exactly 1 clk after rom_en
out  out  BITSIZE  signed mixed sample
out_valid  out  1  one-clk pulse when out updates
busy  out  1  frame in progress
overrun  out  1  sticky: lrclk edge arrived while busy

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, busy=0, overrun=0, rom_en=0, rom_addr=0. All phases, freqs, enables, muted flags and the accumulator are 0. State is IDLE.
- lrclk passes through a 2-FF synchroniser. A rising edge detected in IDLE starts a frame. An edge detected while not IDLE sets overrun and is otherwise ignored.
- FSM: IDLE -> FETCH -> WAIT -> ACC, looping FETCH..ACC for voice v=0..VOICES-1 -> DONE -> IDLE. A frame takes 3*VOICES+1 clk. busy=1 in every state except IDLE.
- FETCH(v): p = phase[v]. Drive rom_en=1.
  - rom_addr = p[PHASESIZE-2] ? ~p[PHASESIZE-3:PHASESIZE-TABLESIZE-2] : p[PHASESIZE-3:PHASESIZE-TABLESIZE-2].
  - Latch neg = p[PHASESIZE-1].
  - Latch freq[v] and compute np = p + freq[v], modulo 2^PHASESIZE. A wrap occurs when np < p.
- WAIT: rom_en=0. rom_data becomes valid.
- ACC:
  - term = neg ? -rom_data : rom_data, signed, sign-extended to BITSIZE+VOICEBITS bits.
  - If muted[v], term = 0.
  - acc += term.
- Phase update at ACC:
  - If enable[v]=1: phase[v] <= np and muted[v] <= 0.
  - If enable[v]=0 and not muted: phase[v] <= np, and on wrap set muted[v]=1 and phase[v]=0. The voice thus finishes its cycle at the zero crossing, giving click-free stop.
  - If muted and enable[v]=0: phase stays 0.
  - A muted voice re-enabled restarts from phase 0 at its next FETCH.
- DONE: out <= acc >>> VOICEBITS (arithmetic shift, no saturation needed). Pulse out_valid for 1 clk. Clear acc. out holds its value between frames.
- Config writes:
  - Accepted in any state and take effect at that voice's next FETCH.
  - A write to the voice currently between FETCH and ACC affects the next frame only, because freq was latched.
  - A write of enable=0 never zeroes phase directly.
- Reset mid-frame aborts immediately: no out_valid, and overrun is cleared.

Decomposition:
- Shared package sine_pkg:
  - FSM state enum (IDLE, FETCH, WAIT, ACC, DONE).
  - Default BITSIZE/PHASESIZE/TABLESIZE constants.
  - Address-fold and negate-bit functions shared with other oscillator blocks.
- Natural sub-module: quarter_sine_rom (1-clk registered read, $readmemh-initialised, keyed on BITSIZE/TABLESIZE), instantiated by the parent beside the scheduler. Table contents are not part of this block.
- The lrclk synchroniser/edge detector is inline.

Test Plan:
- Bench ROM model table[i]=i*1000. Voice0 freq=0x4000, enable=1, others disabled. Four frames -> out = 0, 127750, 0, -127750 (511000>>>2).
- All four voices freq=0x4000, enable=1. Frame 2 (phase 0x4000) -> out=511000. Every frame is exactly 13 clk from sync edge to out_valid, with busy high throughout.
- Voice0 freq=0x2000 running, phase 0xA000. Write enable=0 -> voice keeps stepping through 0xC000 and 0xE000. On wrap it is muted with phase 0, and every later out is 0.
- lrclk edges spaced 8 clk apart (shorter than a frame) -> overrun=1 and stays set. Only completed frames pulse out_valid.
- Write freq for voice1 while FSM is in WAIT of voice1 -> current frame uses the old freq, next frame uses the new one.
- Assert resetn low during ACC of voice2 -> out=0, busy=0, no out_valid. The first frame after release starts from phase 0 for all voices.
